ddr_ahb_csr_bank: RTL and testbench
===================================

Name: ddr_ahb_csr_bank

Overview:
Parametrised AHB-Lite slave with an integrated register bank. It provides NUM_CFG read/write config registers and NUM_STA read-only status registers, and replaces the fixed per-block slave-plus-CSR pair in the DDR subsystem. Beyond that pair it adds byte/halfword writes, programmable read wait states, two-cycle ERROR responses and per-register write-strobe pulses. It sits on the DDR AHB fabric, one instance per CSR space.

Parameters:
AWIDTH, 32, AHB address width
DWIDTH, 32, data width; fixed at 32 in this generation
NUM_CFG, 4, config register count (1..64)
NUM_STA, 2, status register count (0..64)
OFFS_W, 12, decoded address offset bits (haddr[OFFS_W-1:0])
CFG_RST, '0, NUM_CFG*DWIDTH packed config reset values (reg k at [k*DWIDTH +: DWIDTH])
RD_WAIT, 0, extra wait states on reads (0..3)

Ports:
i_hclk  in  1  clock
i_hreset  in  1  asynchronous active-low reset
i_haddr  in  AWIDTH  address
i_hwrite  in  1  write=1
i_hsel  in  1  slave select
i_hwdata  in  DWIDTH  write data (data phase)
i_htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
i_hsize  in  3  transfer size
i_hburst  in  3  ignored; every beat is decoded independently
i_hreadyin  in  1  bus ready
o_hready  out  1  slave ready
o_hrdata  out  DWIDTH  read data
o_hresp  out  2  OKAY=0, ERROR=1
o_cfg  out  NUM_CFG*DWIDTH  config register contents
o_cfg_wr  out  NUM_CFG  one-cycle pulse when the register is written
i_sta  in  NUM_STA*DWIDTH  status inputs

Behaviour:
- Reset values: o_hready=1, o_hresp=OKAY, o_hrdata=0, o_cfg=CFG_RST, o_cfg_wr=0, state=IDLE. A reset mid-transfer aborts the transfer; any pending write is discarded.
- Register map: cfg k at offset 4k; sta j at offset 4*(NUM_CFG+j).
- Accept condition: i_hsel & i_hreadyin & i_htrans[1] while o_hready=1. On accept, latch addr offset, hwrite, hsize. IDLE/BUSY transfers get a zero-wait OKAY.
- Error on accept when any of these hold:
  - offset beyond the last register;
  - write to a status register;
  - hsize>2;
  - misaligned access (halfword with haddr[0]=1, word with haddr[1:0]!=0).
- FSM states: IDLE, RWAIT, ERR1, ERR2.
- IDLE, accepted error: go to ERR1.
- IDLE, accepted read with RD_WAIT>0: load counter=RD_WAIT, go to RWAIT.
- IDLE, other accepted transfer: stay in IDLE (zero-wait).
- RWAIT: o_hready=0; counter decrements each cycle; at 1, return to IDLE with o_hready=1 and data valid.
- ERR1: o_hready=0, o_hresp=ERROR. ERR2 (next cycle): o_hready=1, o_hresp=ERROR. Then IDLE, or accept a new transfer in ERR2 when the accept condition holds.
- Write: byte lanes come from the latched hsize/addr[1:0]. The register updates at the clock edge ending the data phase (the first cycle o_hready=1 after accept). o_cfg_wr[k] pulses high for exactly that one cycle. Unselected lanes keep their value.
- Read data: muxed from current register state in the data phase; o_hrdata=0 when not in a read data phase.
- Status path: i_sta is registered once (1-cycle snapshot); reads return the snapshot.
- Pipelining:
  - Back-to-back write then read of the same register returns the new value.
  - Back-to-back writes at full rate are supported.
  - Address phases presented while o_hready=0 are ignored.
- Errored transfers never modify registers and never pulse o_cfg_wr.

Decomposition:
- ddr_global_pkg gains:
  - htrans enum (IDLE/BUSY/NONSEQ/SEQ);
  - hresp enum;
  - hsize constants;
  - csr FSM state typedef.
- One sub-module, ddr_ahb_byte_strb: combinational; hsize + addr[1:0] -> 4-bit lane strobe plus a misalign flag.

Test Plan:
- Reset with CFG_RST=0x..A5A5_0001 (reg0) -> o_cfg reg0=0xA5A5_0001, o_hready=1, o_hresp=0.
- Word write 0xDEADBEEF to 0x4, then byte write 0x12 to 0x5 -> reg1=0xDEAD12EF; o_cfg_wr[1] pulses once per write.
- RD_WAIT=2, read 0x4 -> o_hready low for 2 cycles, then data 0xDEAD12EF with OKAY.
- Write to a status offset (NUM_CFG=4 -> 0x10) -> ERR1 (hready=0, ERROR), ERR2 (hready=1, ERROR); registers unchanged.
- Word access at 0x2, and a read at 0x40 with NUM_STA=2 -> both two-cycle ERROR; the next valid NONSEQ is accepted in ERR2 and returns OKAY.
- i_sta[0]=0x55 then 0xAA on consecutive cycles, read 0x10 -> value matches the registered snapshot; back-to-back write 0x1 then read of 0x0 returns 0x1 with zero wait.

Source files
------------

// File: rtl/ddr_global_pkg.sv
// Shared DDR-subsystem AHB types: transfer/response encodings, size codes, CSR FSM states.
package ddr_global_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        CSR_IDLE,
        CSR_RWAIT,
        CSR_ERR1,
        CSR_ERR2
    } csr_state_e;

endpackage

// File: rtl/ddr_ahb_csr_bank_if.sv
// AHB-Lite slave-side signal bundle for one CSR bank; master drives requests, slave drives responses.
interface ddr_ahb_csr_bank_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic [AWIDTH-1:0] i_haddr;
    logic              i_hwrite;
    logic              i_hsel;
    logic [DWIDTH-1:0] i_hwdata;
    logic [1:0]        i_htrans;
    logic [2:0]        i_hsize;
    logic [2:0]        i_hburst;
    logic              i_hreadyin;
    logic              o_hready;
    logic [DWIDTH-1:0] o_hrdata;
    logic [1:0]        o_hresp;

    modport slave (
        input  i_haddr, i_hwrite, i_hsel, i_hwdata, i_htrans, i_hsize, i_hburst, i_hreadyin,
        output o_hready, o_hrdata, o_hresp
    );

    modport master (
        output i_haddr, i_hwrite, i_hsel, i_hwdata, i_htrans, i_hsize, i_hburst, i_hreadyin,
        input  o_hready, o_hrdata, o_hresp
    );
endinterface

// File: rtl/ddr_ahb_byte_strb.sv
// Byte-lane strobe and alignment check from hsize/addr[1:0].
// Latency: combinational; backpressure: none.
module ddr_ahb_byte_strb
    import ddr_global_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_strb,
    output logic       o_misalign
);

    always_comb begin
        o_strb     = 4'b0000;
        o_misalign = 1'b0;
        case (i_hsize)
            HSIZE_BYTE: o_strb = 4'b0001 << i_addr_lo;
            HSIZE_HALF: begin
                o_strb     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr_lo[0];
            end
            HSIZE_WORD: begin
                o_strb     = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            // oversize transfers are rejected by the caller; no lanes enabled
            default: ;
        endcase
    end

endmodule

// File: rtl/ddr_ahb_csr_bank.sv
// AHB-Lite slave with NUM_CFG r/w config and NUM_STA snapshot status registers.
// Latency: writes/reads zero-wait (reads +RD_WAIT); backpressure via o_hready low in RWAIT/ERR1.
module ddr_ahb_csr_bank
    import ddr_global_pkg::*;
#(
    parameter int                          AWIDTH  = 32,
    parameter int                          DWIDTH  = 32,
    parameter int                          NUM_CFG = 4,
    parameter int                          NUM_STA = 2,
    parameter int                          OFFS_W  = 12,
    parameter logic [NUM_CFG*DWIDTH-1:0]   CFG_RST = '0,
    parameter int                          RD_WAIT = 0
) (
    input  logic                                          i_hclk,
    input  logic                                          i_hreset,
    ddr_ahb_csr_bank_if.slave                             bus,
    output logic [NUM_CFG*DWIDTH-1:0]                     o_cfg,
    output logic [NUM_CFG-1:0]                            o_cfg_wr,
    input  logic [((NUM_STA > 0) ? NUM_STA : 1)*DWIDTH-1:0] i_sta
);

    localparam int              IDX_W    = OFFS_W - 2;
    localparam int              STA_N    = (NUM_STA > 0) ? NUM_STA : 1;
    localparam logic [IDX_W-1:0] CFG_LIM = IDX_W'(NUM_CFG);
    localparam logic [IDX_W-1:0] REG_LIM = IDX_W'(NUM_CFG + NUM_STA);
    localparam bit              HAS_WAIT = (RD_WAIT > 0);

    csr_state_e                      state_q, state_d;
    logic [1:0]                      cnt_q, cnt_d;
    logic                            dph_vld_q, dph_vld_d;
    logic                            dph_wr_q, dph_wr_d;
    logic [IDX_W-1:0]                dph_idx_q, dph_idx_d;
    logic [3:0]                      dph_strb_q, dph_strb_d;
    logic [NUM_CFG-1:0][DWIDTH-1:0]  cfg_q, cfg_d;
    logic [STA_N-1:0][DWIDTH-1:0]    sta_q, sta_d;

    logic             hready;
    logic             acc;
    logic             acc_err;
    logic             misalign;
    logic [3:0]       strb;
    logic [IDX_W-1:0] addr_idx;
    logic [DWIDTH-1:0] rdata;
    logic [NUM_CFG-1:0] cfg_wr;
    logic             unused_bus;

    assign unused_bus = ^{bus.i_hburst, bus.i_htrans[0], bus.i_haddr[AWIDTH-1:OFFS_W]};

    assign addr_idx = bus.i_haddr[OFFS_W-1:2];
    assign hready   = (state_q == CSR_IDLE) || (state_q == CSR_ERR2);
    assign acc      = bus.i_hsel && bus.i_hreadyin && bus.i_htrans[1] && hready;

    ddr_ahb_byte_strb u_strb (
        .i_hsize    (bus.i_hsize),
        .i_addr_lo  (bus.i_haddr[1:0]),
        .o_strb     (strb),
        .o_misalign (misalign)
    );

    assign acc_err = (addr_idx >= REG_LIM)
                  || (bus.i_hwrite && (addr_idx >= CFG_LIM))
                  || (bus.i_hsize > HSIZE_WORD)
                  || misalign;

    // ERR2 behaves like IDLE for new address phases, so both share one branch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CSR_IDLE, CSR_ERR2: begin
                state_d = CSR_IDLE;
                if (acc) begin
                    if (acc_err) begin
                        state_d = CSR_ERR1;
                    end else if (!bus.i_hwrite && HAS_WAIT) begin
                        state_d = CSR_RWAIT;
                        cnt_d   = 2'(RD_WAIT);
                    end
                end
            end
            CSR_RWAIT: begin
                if (cnt_q == 2'd1) state_d = CSR_IDLE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            CSR_ERR1: state_d = CSR_ERR2;
            default:  state_d = CSR_IDLE;
        endcase
    end

    // A data phase ends on every ready cycle; the next one starts only for a clean accept
    always_comb begin
        dph_vld_d  = dph_vld_q;
        dph_wr_d   = dph_wr_q;
        dph_idx_d  = dph_idx_q;
        dph_strb_d = dph_strb_q;
        if (hready) begin
            dph_vld_d = acc && !acc_err;
            if (acc) begin
                dph_wr_d   = bus.i_hwrite;
                dph_idx_d  = addr_idx;
                dph_strb_d = strb;
            end
        end
    end

    always_comb begin
        cfg_d  = cfg_q;
        cfg_wr = '0;
        if (dph_vld_q && dph_wr_q && hready) begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (dph_idx_q == IDX_W'(k)) begin
                    cfg_wr[k] = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (dph_strb_q[b]) cfg_d[k][8*b +: 8] = bus.i_hwdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        sta_d = i_sta;
    end

    always_comb begin
        rdata = '0;
        if (dph_vld_q && !dph_wr_q) begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (dph_idx_q == IDX_W'(k)) rdata = cfg_q[k];
            end
            for (int j = 0; j < NUM_STA; j++) begin
                if (dph_idx_q == IDX_W'(NUM_CFG + j)) rdata = sta_q[j];
            end
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            state_q    <= CSR_IDLE;
            cnt_q      <= '0;
            dph_vld_q  <= 1'b0;
            dph_wr_q   <= 1'b0;
            dph_idx_q  <= '0;
            dph_strb_q <= '0;
            cfg_q      <= CFG_RST;
            sta_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dph_vld_q  <= dph_vld_d;
            dph_wr_q   <= dph_wr_d;
            dph_idx_q  <= dph_idx_d;
            dph_strb_q <= dph_strb_d;
            cfg_q      <= cfg_d;
            sta_q      <= sta_d;
        end
    end

    assign bus.o_hready = hready;
    assign bus.o_hrdata = rdata;
    assign bus.o_hresp  = ((state_q == CSR_ERR1) || (state_q == CSR_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign o_cfg        = cfg_q;
    assign o_cfg_wr     = cfg_wr;

endmodule

// File: tb/tb_ddr_ahb_csr_bank.sv
// Scoreboarded bench for ddr_ahb_csr_bank: a RD_WAIT=2 bank for most traffic, a RD_WAIT=0 bank for zero-wait hazard.
module tb_ddr_ahb_csr_bank;
    import ddr_global_pkg::*;

    localparam logic [127:0] RST_VAL = {32'h0, 32'h0, 32'h0, 32'hA5A5_0001};

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [1:0]  resp;
        int          waits;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] cfg_a, cfg_b;
    logic [3:0]   cfg_wr_a, cfg_wr_b;
    logic [31:0]  sta_v [2];
    logic [63:0]  sta;
    logic [31:0]  mdl [4];

    exp_t sbq [$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_bad = 0;
    int   nid   = 0;
    int   wr_cnt [4];
    bit   pend;
    int   waits;

    assign sta = {sta_v[1], sta_v[0]};

    always #5 clk = ~clk;

    ddr_ahb_csr_bank_if #(.AWIDTH(32), .DWIDTH(32)) bus  ();
    ddr_ahb_csr_bank_if #(.AWIDTH(32), .DWIDTH(32)) bus0 ();

    ddr_ahb_csr_bank #(
        .AWIDTH(32), .DWIDTH(32), .NUM_CFG(4), .NUM_STA(2), .OFFS_W(12),
        .CFG_RST(RST_VAL), .RD_WAIT(2)
    ) u_dut (
        .i_hclk(clk), .i_hreset(rst_n), .bus(bus),
        .o_cfg(cfg_a), .o_cfg_wr(cfg_wr_a), .i_sta(sta)
    );

    ddr_ahb_csr_bank #(
        .AWIDTH(32), .DWIDTH(32), .NUM_CFG(4), .NUM_STA(2), .OFFS_W(12),
        .CFG_RST(RST_VAL), .RD_WAIT(0)
    ) u_dut0 (
        .i_hclk(clk), .i_hreset(rst_n), .bus(bus0),
        .o_cfg(cfg_b), .o_cfg_wr(cfg_wr_b), .i_sta(sta)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic bit lane_en(input logic [2:0] size, input logic [1:0] a, input int b);
        case (size)
            HSIZE_BYTE: return b == int'(a);
            HSIZE_HALF: return (b / 2) == int'(a[1]);
            default:    return 1'b1;
        endcase
    endfunction

    // Response monitor: the oldest queued expectation belongs to the data phase in flight
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'(sbq.size()), 32'd1);
                    pend = 1'b0;
                end else if (!bus.o_hready) begin
                    waits++;
                    if (sbq[0].resp == HRESP_ERROR)
                        chk($sformatf("x%0d_err1_resp", sbq[0].id), 32'(bus.o_hresp), 32'(HRESP_ERROR));
                end else begin
                    mon_e = sbq.pop_front();
                    chk($sformatf("x%0d_waits", mon_e.id), 32'(waits), 32'(mon_e.waits));
                    chk($sformatf("x%0d_resp", mon_e.id), 32'(bus.o_hresp), 32'(mon_e.resp));
                    chk($sformatf("x%0d_rdata", mon_e.id), bus.o_hrdata, mon_e.data);
                    pend = 1'b0;
                end
            end
            if (bus.o_hready && bus.i_hsel && bus.i_hreadyin && bus.i_htrans[1]) begin
                pend  = 1'b1;
                waits = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) if (cfg_wr_a[k]) wr_cnt[k]++;
        end
    end

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input exp_t e);
        int t;
        bus.i_hsel   = 1'b1;
        bus.i_htrans = HTRANS_NONSEQ;
        bus.i_haddr  = addr;
        bus.i_hwrite = wr;
        bus.i_hsize  = size;
        sbq.push_back(e);
        t = 0;
        @(negedge clk);
        while (!bus.o_hready && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (t >= 20) chk("accept_timeout", 32'(bus.o_hready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_hwdata = wdata;
        bus.i_hsel   = 1'b0;
        bus.i_htrans = HTRANS_IDLE;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata, input bit err);
        exp_t e;
        int   idx;
        e.id    = nid++;
        e.data  = 32'h0;
        e.resp  = err ? HRESP_ERROR : HRESP_OKAY;
        e.waits = err ? 1 : 0;
        if (!err) begin
            idx = int'(addr[11:2]);
            for (int b = 0; b < 4; b++)
                if (lane_en(size, addr[1:0], b)) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        xfer(1'b1, addr, size, wdata, e);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [2:0] size, input bit err);
        exp_t e;
        int   idx;
        idx     = int'(addr[11:2]);
        e.id    = nid++;
        e.resp  = err ? HRESP_ERROR : HRESP_OKAY;
        e.waits = err ? 1 : 2;
        if (err)          e.data = 32'h0;
        else if (idx < 4) e.data = mdl[idx];
        else              e.data = sta_v[idx-4];
        xfer(1'b0, addr, size, 32'h0, e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sbq.size() != 0 || pend) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    initial begin
        int sum;
        rst_n = 1'b0;
        sta_v[0] = 32'h0;
        sta_v[1] = 32'h1234_5678;
        mdl[0] = 32'hA5A5_0001; mdl[1] = 32'h0; mdl[2] = 32'h0; mdl[3] = 32'h0;
        for (int k = 0; k < 4; k++) wr_cnt[k] = 0;
        bus.i_haddr = '0;  bus.i_hwrite = 1'b0; bus.i_hsel = 1'b0; bus.i_hwdata = '0;
        bus.i_htrans = HTRANS_IDLE; bus.i_hsize = HSIZE_WORD; bus.i_hburst = 3'd0; bus.i_hreadyin = 1'b1;
        bus0.i_haddr = '0; bus0.i_hwrite = 1'b0; bus0.i_hsel = 1'b0; bus0.i_hwdata = '0;
        bus0.i_htrans = HTRANS_IDLE; bus0.i_hsize = HSIZE_WORD; bus0.i_hburst = 3'd0; bus0.i_hreadyin = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg0", cfg_a[31:0], 32'hA5A5_0001);
        chk("rst_cfg1", cfg_a[63:32], 32'h0);
        chk("rst_hready", 32'(bus.o_hready), 32'd1);
        chk("rst_hresp", 32'(bus.o_hresp), 32'd0);
        chk("rst_hrdata", bus.o_hrdata, 32'h0);
        chk("rst_cfg_wr", 32'(cfg_wr_a), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // word write, byte patch, then a waited read of the same register
        wr(32'h4, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0);
        wr(32'h5, HSIZE_BYTE, 32'h0000_1200, 1'b0);
        rd(32'h4, HSIZE_WORD, 1'b0);
        drain();
        chk("cfg1_after_wr", cfg_a[63:32], 32'hDEAD_12EF);
        chk("cfg1_pulses", 32'(wr_cnt[1]), 32'd2);

        // error chain: each new transfer is taken in the ERR2 of the previous one
        wr(32'h10, HSIZE_WORD, 32'hFFFF_FFFF, 1'b1);
        wr(32'h8,  3'd3,       32'hFFFF_FFFF, 1'b1);
        wr(32'h9,  HSIZE_HALF, 32'hFFFF_FFFF, 1'b1);
        rd(32'h2,  HSIZE_WORD, 1'b1);
        rd(32'h40, HSIZE_WORD, 1'b1);
        rd(32'h0,  HSIZE_WORD, 1'b0);
        rd(32'h18, HSIZE_WORD, 1'b1);
        drain();
        for (int k = 0; k < 4; k++) chk($sformatf("cfg%0d_after_err", k), cfg_a[32*k +: 32], mdl[k]);
        sum = wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3];
        chk("pulses_after_err", 32'(sum), 32'd2);

        wr(32'hA, HSIZE_HALF, 32'hBEEF_0000, 1'b0);
        rd(32'h8, HSIZE_WORD, 1'b0);
        rd(32'h14, HSIZE_WORD, 1'b0);
        drain();
        chk("cfg2_half", cfg_a[95:64], 32'hBEEF_0000);

        sta_v[0] = 32'h55;
        @(posedge clk);
        #1 sta_v[0] = 32'hAA;
        rd(32'h10, HSIZE_WORD, 1'b0);
        drain();

        // BUSY with select must be a zero-wait OKAY, even at an out-of-range address
        bus.i_hsel = 1'b1; bus.i_htrans = HTRANS_BUSY; bus.i_haddr = 32'h40; bus.i_hwrite = 1'b0;
        @(negedge clk);
        chk("busy_hready", 32'(bus.o_hready), 32'd1);
        @(posedge clk);
        #1 bus.i_hsel = 1'b0; bus.i_htrans = HTRANS_IDLE;
        @(negedge clk);
        chk("busy_hresp", 32'(bus.o_hresp), 32'd0);
        chk("busy_hready2", 32'(bus.o_hready), 32'd1);
        @(posedge clk);
        #1;

        // zero-wait bank: write 1 to reg0, read it back in the very next beat
        bus0.i_hsel = 1'b1; bus0.i_htrans = HTRANS_NONSEQ; bus0.i_haddr = 32'h0;
        bus0.i_hwrite = 1'b1; bus0.i_hsize = HSIZE_WORD;
        @(posedge clk);
        #1 bus0.i_hwdata = 32'h1; bus0.i_hwrite = 1'b0;
        @(negedge clk);
        chk("b_wr_pulse", 32'(cfg_wr_b), 32'h1);
        chk("b_wr_hready", 32'(bus0.o_hready), 32'd1);
        @(posedge clk);
        #1 bus0.i_hsel = 1'b0; bus0.i_htrans = HTRANS_IDLE;
        @(negedge clk);
        chk("b_rd_hready", 32'(bus0.o_hready), 32'd1);
        chk("b_rd_data", bus0.o_hrdata, 32'h1);
        chk("b_rd_resp", 32'(bus0.o_hresp), 32'd0);
        chk("b_rd_no_pulse", 32'(cfg_wr_b), 32'h0);
        chk("b_cfg0", cfg_b[31:0], 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b_idle_rdata", bus0.o_hrdata, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
